spi_slave_top: RTL and testbench

- SPI slave (mode 3: SCLK idles high, MOSI sampled on SCLK rising edge, MSB first, CS active low) fully resampled into the clk50m domain.
- Deserialises bytes and decodes a command/data protocol into an 8 x 8-bit register file.
- Exposes received bytes, write strobes and a register read-back port to the rest of the FPGA design.

---
 rtl/spi_slave_top_if.sv | 35 +++
 rtl/spi_slave_top.sv | 209 ++++++++++++++++++++
 tb/tb_spi_slave_top.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_top_if.sv
// Local-side bus of the SPI slave: received byte stream, register write
// strobes and the register read-back port, plus a debug view of the
// frame FSM state.
//
// Handshake: rx_valid and reg_wr_en are single-cycle strobes qualified by
// nothing else; there is no ready, because an SPI master cannot be stalled.
// rx_data / reg_wr_addr / reg_wr_data are valid in the cycle the strobe is
// high and hold their value afterwards.
interface spi_slave_top_if #(
    parameter int ADDR_W = 3
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              frame_active;
    logic              reg_wr_en;
    logic [ADDR_W-1:0] reg_wr_addr;
    logic [7:0]        reg_wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [1:0]        dbg_state;

    // Design side
    modport slave (
        output rx_data, rx_valid, frame_active, reg_wr_en,
        output reg_wr_addr, reg_wr_data, rd_data, dbg_state,
        input  rd_addr
    );

    // Consumer side
    modport master (
        input  rx_data, rx_valid, frame_active, reg_wr_en,
        input  reg_wr_addr, reg_wr_data, rd_data, dbg_state,
        output rd_addr
    );
endinterface

// File: rtl/spi_slave_top.sv
// SPI mode-3 slave, fully oversampled in the clk50m domain. Decodes a
// command byte (bit7 = write, low bits = start address) followed by data
// bytes into a small register file with auto-incrementing address.
// Optional macro MISO_EN adds the miso output and the TX shift path
// (status byte 0xA5, then register contents on read frames).
module spi_slave_top #(
    parameter int NUM_REGS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk50m,
    input  logic rst,
    input  logic sclk,
    input  logic cs,
    input  logic mosi,
`ifdef MISO_EN
    output logic miso,
`endif
    spi_slave_top_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    // WAIT_CS_HIGH: after reset, ignore the bus until cs has been seen high.
    typedef enum logic [1:0] {
        S_WAIT_CS_HIGH = 2'd0,
        S_IDLE         = 2'd1,
        S_CMD          = 2'd2,
        S_DATA         = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_rise;

    logic                   in_frame;
    logic                   rx_enable;

    logic [2:0]             bit_cnt;
    logic [7:0]             shift_q;
    logic [7:0]             byte_nxt;
    logic                   cmd_wr;
    logic [ADDR_W-1:0]      addr;

    logic [7:0]             rx_data_q;
    logic                   rx_valid_q;
    logic                   wr_en_q;
    logic [ADDR_W-1:0]      wr_addr_q;
    logic [7:0]             wr_data_q;
    logic [7:0]             regs [NUM_REGS];

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign byte_nxt  = {shift_q[6:0], mosi_s};

    // Resample the SPI pins. The cs chain resets to 0 (selected) so that a
    // reset taken mid-frame cannot see a false "cs high" while the chain
    // flushes; the frame only restarts after a genuine cs rise.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            sclk_sync <= '1;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            state <= S_WAIT_CS_HIGH;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame FSM next state: cs high always ends a frame; the command byte
    // is followed by data bytes until cs rises.
    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT_CS_HIGH: if (cs_s) state_nxt = S_IDLE;
            S_IDLE:         if (!cs_s) state_nxt = S_CMD;
            S_CMD: begin
                if (cs_s) begin
                    state_nxt = S_IDLE;
                end else if (sclk_rise && bit_cnt == 3'd7) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA:         if (cs_s) state_nxt = S_IDLE;
            default:        state_nxt = S_WAIT_CS_HIGH;
        endcase
    end

    // Frame FSM outputs.
    always_comb begin
        in_frame  = (state == S_CMD) || (state == S_DATA);
        rx_enable = in_frame && !cs_s;
    end

    // Deserialiser and command decode; strobes default low each cycle.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            bit_cnt    <= 3'd0;
            shift_q    <= 8'h00;
            cmd_wr     <= 1'b0;
            addr       <= '0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
        end else begin
            rx_valid_q <= 1'b0;
            wr_en_q    <= 1'b0;
            if (!rx_enable) begin
                bit_cnt <= 3'd0;
                shift_q <= 8'h00;
            end else if (sclk_rise) begin
                shift_q <= byte_nxt;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_data_q  <= byte_nxt;
                    rx_valid_q <= 1'b1;
                    if (state == S_CMD) begin
                        cmd_wr <= byte_nxt[7];
                        addr   <= byte_nxt[ADDR_W-1:0];
                    end else begin
                        if (cmd_wr) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= addr;
                            wr_data_q <= byte_nxt;
                        end
                        addr <= addr + 1'b1;
                    end
                end
            end
        end
    end

    // Register file: written from the registered strobe, so a local read in
    // the strobe cycle still returns the previous contents.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (wr_en_q) begin
            regs[wr_addr_q] <= wr_data_q;
        end
    end

`ifdef MISO_EN
    logic [7:0]        tx_sr;
    logic [ADDR_W-1:0] addr_inc;

    assign addr_inc = addr + 1'b1;

    // TX shifter: status byte at frame start, then one byte per boundary.
    // The shift happens right after each rise, leaving a full SCLK phase of
    // settling before the master samples the next bit. On read frames the
    // reload is the register the upcoming byte addresses.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            tx_sr <= 8'h00;
        end else if (state == S_IDLE && !cs_s) begin
            tx_sr <= 8'hA5;
        end else if (rx_enable && sclk_rise) begin
            if (bit_cnt == 3'd7) begin
                if (state == S_CMD) begin
                    tx_sr <= byte_nxt[7] ? 8'h00 : regs[byte_nxt[ADDR_W-1:0]];
                end else begin
                    tx_sr <= cmd_wr ? 8'h00 : regs[addr_inc];
                end
            end else begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
        end
    end

    // miso idles high outside a frame.
    always_comb begin
        miso = in_frame ? tx_sr[7] : 1'b1;
    end
`endif

    assign bus.rx_data      = rx_data_q;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.frame_active = in_frame;
    assign bus.reg_wr_en    = wr_en_q;
    assign bus.reg_wr_addr  = wr_addr_q;
    assign bus.reg_wr_data  = wr_data_q;
    assign bus.rd_data      = regs[bus.rd_addr];
    assign bus.dbg_state    = state;
endmodule

// File: tb/tb_spi_slave_top.sv
// Directed bench for spi_slave_top: mode-3 SPI frames driven with 50 ns
// half-periods, strobes collected by a negedge monitor and compared against
// expected queues; register contents checked against a local model.
module tb_spi_slave_top;
    logic clk = 1'b0;
    logic rst;
    logic sclk;
    logic cs;
    logic mosi;
    logic miso_w;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    logic [10:0] exp_wr_q[$];
    logic [10:0] wr_q[$];
    logic [7:0]  rd_at_wr_q[$];
    logic [7:0]  model [8];
    logic [7:0]  so0;
    logic [7:0]  so1;

    spi_slave_top_if #(.ADDR_W(3)) bus ();

    spi_slave_top #(
        .NUM_REGS   (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk50m(clk),
        .rst   (rst),
        .sclk  (sclk),
        .cs    (cs),
        .mosi  (mosi),
`ifdef MISO_EN
        .miso  (miso_w),
`endif
        .bus   (bus)
    );

`ifndef MISO_EN
    assign miso_w = 1'b1;
`endif

    // Clock / reset block
    always #10 clk = ~clk;

    // Monitor: collect strobes away from the active edge.
    always @(negedge clk) begin
        if (bus.rx_valid) rx_q.push_back(bus.rx_data);
        if (bus.reg_wr_en) begin
            wr_q.push_back({bus.reg_wr_addr, bus.reg_wr_data});
            rd_at_wr_q.push_back(bus.rd_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        while (exp_q.size() > 0 && rx_q.size() > 0) chk(tag, rx_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic check_wr(input string tag);
        chk({tag, "_count"}, wr_q.size(), exp_wr_q.size());
        while (exp_wr_q.size() > 0 && wr_q.size() > 0) chk(tag, wr_q.pop_front(), exp_wr_q.pop_front());
        exp_wr_q.delete();
        wr_q.delete();
    endtask

    task automatic check_regs(input string tag);
        for (int a = 0; a < 8; a++) begin
            bus.rd_addr = 3'(a);
            #1;
            chk($sformatf("%s_reg%0d", tag, a), bus.rd_data, model[a]);
        end
    endtask

    // Driver: mode 3, data changes with SCLK low, miso sampled at the rise.
    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] so);
        so = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            sclk = 1'b0;
            mosi = b[i];
            #50;
            so   = {so[6:0], miso_w};
            sclk = 1'b1;
            #50;
        end
    endtask

    task automatic cs_begin();
        @(posedge clk);
        #3;
        cs = 1'b0;
        #100;
    endtask

    task automatic cs_end();
        #100;
        cs = 1'b1;
        #200;
    endtask

    initial begin
        rst  = 1'b1;
        cs   = 1'b1;
        sclk = 1'b1;
        mosi = 1'b0;
        bus.rd_addr = 3'd0;
        for (int a = 0; a < 8; a++) model[a] = 8'h00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Reset state
        chk("rst_rx_data", bus.rx_data, 8'h00);
        chk("rst_rx_valid", bus.rx_valid, 1'b0);
        chk("rst_frame_active", bus.frame_active, 1'b0);
        chk("rst_wr_en", bus.reg_wr_en, 1'b0);
        chk("rst_wr_addr", bus.reg_wr_addr, 3'd0);
        chk("rst_wr_data", bus.reg_wr_data, 8'h00);
`ifdef MISO_EN
        chk("rst_miso", miso_w, 1'b1);
`endif
        check_regs("rst");
        check_rx("rst_rx");

        // Write frame: reg5 <= 0x10
        bus.rd_addr = 3'd5;
        exp_q.push_back(8'hB5);
        exp_q.push_back(8'h10);
        exp_wr_q.push_back({3'd5, 8'h10});
        cs_begin();
        chk("f1_frame_active", bus.frame_active, 1'b1);
        spi_bits(8'hB5, 8, so0);
        spi_bits(8'h10, 8, so1);
        cs_end();
        chk("f1_rd_old_in_wr_cycle", (rd_at_wr_q.size() > 0) ? rd_at_wr_q[0] : 8'hxx, 8'h00);
        rd_at_wr_q.delete();
        check_rx("f1_rx");
        check_wr("f1_wr");
        chk("f1_rx_data_hold", bus.rx_data, 8'h10);
        chk("f1_frame_idle", bus.frame_active, 1'b0);
        chk("f1_rd5", bus.rd_data, 8'h10);
        model[5] = 8'h10;

        // Burst write with address wrap
        exp_q.push_back(8'h87);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_wr_q.push_back({3'd7, 8'h11});
        exp_wr_q.push_back({3'd0, 8'h22});
        cs_begin();
        spi_bits(8'h87, 8, so0);
        spi_bits(8'h11, 8, so0);
        spi_bits(8'h22, 8, so0);
        cs_end();
        check_rx("f2_rx");
        check_wr("f2_wr");
        model[7] = 8'h11;
        model[0] = 8'h22;
        check_regs("f2");

        // Partial byte discarded at cs rise
        cs_begin();
        spi_bits(8'h81, 5, so0);
        cs_end();
        check_rx("f3_partial_rx");
        check_wr("f3_partial_wr");
        chk("f3_rx_data_hold", bus.rx_data, 8'h22);
        exp_q.push_back(8'h82);
        exp_q.push_back(8'h33);
        exp_wr_q.push_back({3'd2, 8'h33});
        cs_begin();
        spi_bits(8'h82, 8, so0);
        spi_bits(8'h33, 8, so0);
        cs_end();
        check_rx("f3_rx");
        check_wr("f3_wr");
        model[2] = 8'h33;
        check_regs("f3");

        // Read frame: no write; miso returns status then reg5
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h00);
        cs_begin();
        spi_bits(8'h05, 8, so0);
        spi_bits(8'h00, 8, so1);
        cs_end();
`ifdef MISO_EN
        chk("f4_miso_status", so0, 8'hA5);
        chk("f4_miso_reg5", so1, 8'h10);
        chk("f4_miso_idle", miso_w, 1'b1);
`endif
        check_rx("f4_rx");
        check_wr("f4_wr");
        check_regs("f4");

        // Reset mid-byte; cs stays low so the bus must stay ignored
        cs_begin();
        spi_bits(8'hF0, 4, so0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 8; a++) model[a] = 8'h00;
        @(posedge clk);
        #3;
        spi_bits(8'hFF, 8, so0);
        spi_bits(8'h81, 8, so0);
        #200;
        check_rx("f5_blocked_rx");
        check_wr("f5_blocked_wr");
        chk("f5_rx_data_cleared", bus.rx_data, 8'h00);
        check_regs("f5_cleared");
        cs_end();
        exp_q.push_back(8'h83);
        exp_q.push_back(8'h44);
        exp_wr_q.push_back({3'd3, 8'h44});
        cs_begin();
        spi_bits(8'h83, 8, so0);
        spi_bits(8'h44, 8, so0);
        cs_end();
        check_rx("f5_rx");
        check_wr("f5_wr");
        model[3] = 8'h44;
        check_regs("f5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
